// File: rtl/fp12_pkg.sv
// Shared definitions for the fp12 arithmetic blocks: field widths, bias, operand struct and FSM encodings.
// FP12_DIV_ROUND_EN widens the divider quotient by one round bit.
package fp12_pkg;

  localparam int EXP_W  = 4;
  localparam int MANT_W = 7;
  localparam int BIAS   = 7;
  localparam int FP_W   = 1 + EXP_W + MANT_W;

`ifdef FP12_DIV_ROUND_EN
  localparam int Q = MANT_W + 3;
`else
  localparam int Q = MANT_W + 2;
`endif
  localparam int CNT_W = $clog2(Q);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp12_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_NORM   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [EXP_W+MANT_W-1:0] FP12_MAX_MAG = '1;

  // Signed exponent constants, EXP_W+2 bits so under/overflow stays visible
  localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EXP_TOP = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

endpackage

// File: rtl/fp12_div_step.sv
// One restoring-division step: trial subtract, keep or restore, then shift the partial remainder.
module fp12_div_step
  import fp12_pkg::*;
(
  input  logic [MANT_W+1:0] rem,
  input  logic [MANT_W:0]   div,
  output logic [MANT_W+1:0] rem_next,
  output logic              qbit
);

  logic [MANT_W+1:0] diff;
  logic [MANT_W+1:0] sel;

  assign qbit     = (rem >= {1'b0, div});
  assign diff     = rem - {1'b0, div};
  // sel is always below the divisor, so the shift never loses a set bit
  assign sel      = qbit ? diff : rem;
  assign rem_next = sel << 1;

endmodule

// File: rtl/fp12_seq_divider.sv
// Sequential fp12 divider, one quotient bit per cycle, valid/ready on both sides.
// Define FP12_DIV_ROUND_EN for round-to-nearest-even instead of truncation.
module fp12_seq_divider
  import fp12_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] x,
  input  logic [FP_W-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] result,
  output logic [2:0]      flags
);

  logic [1:0]             state;
  fp12_t                  xr;
  fp12_t                  yr;
  logic [MANT_W+1:0]      rem;
  logic [MANT_W+1:0]      rem_next;
  logic                   qbit;
  logic [Q-1:0]           quo;
  logic [CNT_W-1:0]       cnt;
  logic signed [EXP_W+1:0] exp_base;
  logic signed [EXP_W+1:0] exp_v;
  logic [MANT_W-1:0]      mant_v;
  logic                   sign;
  logic [FP_W-1:0]        norm_res;
  logic [2:0]             norm_flags;
`ifdef FP12_DIV_ROUND_EN
  logic                   rnd;
  logic                   sticky;
  logic [MANT_W:0]        mant_sum;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  fp12_div_step u_step (
    .rem      (rem),
    .div      ({1'b1, yr.mant}),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign exp_base = $signed({2'b00, xr.exp}) - $signed({2'b00, yr.exp}) + BIAS_S;

  always_comb begin
    exp_v  = exp_base;
    mant_v = quo[Q-2 -: MANT_W];
`ifdef FP12_DIV_ROUND_EN
    rnd    = quo[Q-2-MANT_W];
    sticky = quo[0] | (|rem);
`endif
    // Quotient below 1.0: the leading one sits one bit lower
    if (!quo[Q-1]) begin
      exp_v  = exp_base - EXP_ONE;
      mant_v = quo[Q-3 -: MANT_W];
`ifdef FP12_DIV_ROUND_EN
      rnd    = quo[0];
      sticky = |rem;
`endif
    end
`ifdef FP12_DIV_ROUND_EN
    mant_sum = {1'b0, mant_v} + {{MANT_W{1'b0}}, rnd & (sticky | mant_v[0])};
    mant_v   = mant_sum[MANT_W-1:0];
    if (mant_sum[MANT_W]) exp_v = exp_v + EXP_ONE;
`endif
    sign       = xr.sign ^ yr.sign;
    norm_res   = {sign, exp_v[EXP_W-1:0], mant_v};
    norm_flags = 3'b000;
    if (yr.exp == '0) begin
      norm_res   = {sign, FP12_MAX_MAG};
      norm_flags = 3'b100;
    end else if (xr.exp == '0) begin
      norm_res   = {sign, {(FP_W-1){1'b0}}};
    end else if (exp_v > EXP_TOP) begin
      norm_res   = {sign, FP12_MAX_MAG};
      norm_flags = 3'b010;
    end else if (exp_v < EXP_ONE) begin
      norm_res   = {sign, {(FP_W-1){1'b0}}};
      norm_flags = 3'b001;
    end
  end

  // Special operands still run the full iteration count to keep latency fixed
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      xr     <= '0;
      yr     <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            xr    <= x;
            yr    <= y;
            rem   <= {1'b0, 1'b1, x[MANT_W-1:0]};
            quo   <= '0;
            cnt   <= '0;
            state <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          rem <= rem_next;
          quo <= {quo[Q-2:0], qbit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(Q - 1)) state <= ST_NORM;
        end
        ST_NORM: begin
          result <= norm_res;
          flags  <= norm_flags;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
